// File: rtl/bsram.sv
// Single-clock block SRAM: one write port, one registered read port with
// write-first bypass. The array is named sram so benches can preload it.
module bsram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  readEnable,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  output logic [DATA_WIDTH-1:0] readData,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  scan
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] sram [DEPTH];
  logic [DATA_WIDTH-1:0] read_data_q;
  logic [DATA_WIDTH-1:0] read_data_d;
  logic                  bypass;

  // Writes are deliberately independent of reset: contents survive it.
  always_ff @(posedge clock) begin
    if (writeEnable) begin
      sram[writeAddress] <= writeData;
    end
  end

  assign bypass = writeEnable && (readAddress == writeAddress);

  always_comb begin
    read_data_d = read_data_q;
    if (readEnable) begin
      read_data_d = bypass ? writeData : sram[readAddress];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign readData = read_data_q;

`ifndef SYNTHESIS
  // Debug trace only; never affects the datapath.
  always @(posedge clock) begin
    if (scan) begin
      $display("bsram t=%0t re=%0b ra=%0h rd=%0h we=%0b wa=%0h wd=%0h",
               $time, readEnable, readAddress, readData,
               writeEnable, writeAddress, writeData);
    end
  end
`endif

endmodule

// File: tb/tb_bsram.sv
// Directed bench for bsram: an array model checked every cycle plus
// literal expectations for each step of the scenario.
module tb_bsram;

  logic        clock = 1'b0;
  logic        reset;
  logic        readEnable;
  logic [7:0]  readAddress;
  logic [31:0] readData;
  logic        writeEnable;
  logic [7:0]  writeAddress;
  logic [31:0] writeData;
  logic        scan;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [256];
  logic [31:0] model_rd = '0;
  bit          model_live = 1'b0;

  bsram #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .readEnable  (readEnable),
    .readAddress (readAddress),
    .readData    (readData),
    .writeEnable (writeEnable),
    .writeAddress(writeAddress),
    .writeData   (writeData),
    .scan        (scan)
  );

  always #5 clock = ~clock;

  // Model: apply the write to the memory first, then a read sees the
  // post-write memory (write-first). Reset forces the output to zero.
  always @(posedge clock) begin
    if (writeEnable) model_mem[writeAddress] = writeData;
    if (reset) begin
      model_rd   = '0;
      model_live = 1'b1;
    end else if (readEnable) begin
      model_rd = model_mem[readAddress];
    end
  end

  always @(negedge clock) begin
    if (model_live) begin
      checks++;
      if (readData !== model_rd) begin
        failures++;
        $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, readData, model_rd);
      end
    end
  end

  task automatic cycle(input logic rst, input logic re, input logic [7:0] ra,
                       input logic we, input logic [7:0] wa, input logic [31:0] wd);
    reset        = rst;
    readEnable   = re;
    readAddress  = ra;
    writeEnable  = we;
    writeAddress = wa;
    writeData    = wd;
    @(posedge clock);
    #1;
    $display("txn rst=%0b re=%0b ra=%0h we=%0b wa=%0h wd=%h -> rd=%h",
             rst, re, ra, we, wa, wd, readData);
  endtask

  task automatic expect_rd(input string name, input logic [31:0] exp);
    checks++;
    if (readData !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, readData, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] v);
    dut.sram[a] = v;
    model_mem[a] = v;
  endtask

  initial begin
    scan = 1'b0;
    // 1: reset, no reads
    cycle(1, 0, 0, 0, 0, 0);
    expect_rd("reset_zero", 32'h0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    expect_rd("idle_after_reset", 32'h0);

    // 2: preload and read
    preload(8'd0, 32'h0BAD0000);
    preload(8'd2, 32'hAAAA8888);
    preload(8'd4, 32'h11110000);
    cycle(0, 1, 8'd2, 0, 0, 0);
    expect_rd("read_a2", 32'hAAAA8888);

    // 3: same-address write/read bypass, then hold
    cycle(0, 1, 8'd2, 1, 8'd2, 32'h100);
    expect_rd("bypass_a2", 32'h100);
    cycle(0, 0, 8'd4, 0, 0, 0);
    expect_rd("hold_1", 32'h100);
    cycle(0, 0, 8'd0, 0, 0, 0);
    expect_rd("hold_2", 32'h100);

    // 4: neighbour undisturbed
    cycle(0, 1, 8'd4, 0, 0, 0);
    expect_rd("read_a4", 32'h11110000);

    // 5: top address, no aliasing with 0
    cycle(0, 0, 8'd0, 1, 8'd255, 32'hDEADBEEF);
    expect_rd("hold_during_write", 32'h11110000);
    cycle(0, 1, 8'd0, 0, 0, 0);
    expect_rd("read_a0", 32'h0BAD0000);
    cycle(0, 1, 8'd255, 0, 0, 0);
    expect_rd("read_a255", 32'hDEADBEEF);
    cycle(0, 1, 8'd2, 1, 8'd9, 32'h12345678);
    expect_rd("read_diff_addr", 32'h100);
    cycle(0, 1, 8'd9, 0, 0, 0);
    expect_rd("read_a9", 32'h12345678);

    // 6: reset mid-operation, write during reset retained
    cycle(0, 1, 8'd4, 0, 0, 0);
    expect_rd("pre_reset_a4", 32'h11110000);
    cycle(1, 1, 8'd2, 1, 8'd7, 32'h77);
    expect_rd("reset_clears", 32'h0);
    cycle(0, 0, 8'd0, 0, 0, 0);
    expect_rd("post_reset_idle", 32'h0);
    cycle(0, 1, 8'd2, 0, 0, 0);
    expect_rd("retained_a2", 32'h100);
    cycle(0, 1, 8'd7, 0, 0, 0);
    expect_rd("write_in_reset_a7", 32'h77);

    // Trace enable has no functional effect.
    scan = 1'b1;
    cycle(0, 1, 8'd255, 0, 0, 0);
    scan = 1'b0;
    expect_rd("scan_read_a255", 32'hDEADBEEF);

    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsram.md
# bsram

Single-clock block SRAM with one read port and one write port. It is used as the backing store for caches and main-memory models. Reads are registered, so data is available one cycle after the request. A same-cycle read and write to the same address returns the new data. The storage array is exposed under a fixed instance name so that benches can preload it hierarchically.

## Interface

Parameters:
- DATA_WIDTH, default 32: word width in bits.
- ADDR_WIDTH, default 8: address width; depth is 2^ADDR_WIDTH words.

Ports:
- clock, input, 1: the only clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- readEnable, input, 1: read request, sampled at the rising edge.
- readAddress, input, ADDR_WIDTH: read word address.
- readData, output, DATA_WIDTH: registered read data.
- writeEnable, input, 1: write request, sampled at the rising edge.
- writeAddress, input, ADDR_WIDTH: write word address.
- writeData, input, DATA_WIDTH: write data.
- scan, input, 1: debug-trace enable; simulation only, no functional effect.

## Operation

- Storage: an array named sram, of 2^ADDR_WIDTH words × DATA_WIDTH bits. The name sram is mandatory; benches write sram[i] directly.
- Write: at a rising edge with writeEnable=1, sram[writeAddress] is set to writeData.
- Read: at a rising edge with readEnable=1, readData is set to sram[readAddress].
- Read bypass: if readEnable=1, writeEnable=1 and readAddress==writeAddress at the same edge, readData gets writeData (write-first).
- readEnable=0: readData holds its previous value. It is not cleared.
- Reset: when reset=1 at an edge, readData is set to 0 and no read update occurs.
  - The array is not cleared by reset.
  - A write presented while reset=1 is still performed.
  - Hierarchical preloads made during or after reset persist.
- Addresses cover the full range; there is no out-of-range case.
- scan=1: each cycle, simulation-only $display prints the time, readEnable, readAddress, readData, writeEnable, writeAddress and writeData. Guard it with synthesis translate_off/on.

## Timing

- Read latency: 1 cycle. A request at edge N is visible on readData after edge N.
- Write latency: the array is updated at edge N. A read of the same address at edge N returns the new data via bypass; a read at edge N+1 reads it from the array.
- Back-to-back reads and writes are allowed every cycle with no stalls and no handshake.
- Reset value of readData: 0 from the first edge with reset=1.
- Reset mid-operation:
  - An in-flight read result is discarded and readData is 0.
  - After reset is released, the first read returns array contents. Writes made before and during reset are retained.

## Structure

- Single module, no sub-modules. No shared package is needed.
- Parameters are local to the module.
- The optional debug-trace task lives inside the module, simulation-only.

## Test plan

1. Reset, then readEnable=0: readData=0 while reset is high and stays 0 after release.
2. Preload sram[2]=AAAA8888 and sram[4]=11110000. Read address 2: readData=AAAA8888 one edge later.
3. Write 100 to address 2 with readEnable=1 and readAddress=2 in the same cycle. readData=100 after that edge (bypass). Drop readEnable: readData stays 100.
4. Read address 4 after step 3: readData=11110000. The address 2 write did not disturb address 4.
5. Write DEADBEEF to address 255 (the top address), then read address 0 and address 255 separately. Address 255 returns DEADBEEF; address 0 returns its preloaded value (no wrap aliasing).
6. Assert reset while readData=11110000: readData=0. Release reset and read address 2: readData=100 (the array was retained).
